sram_ff_arb: RTL and testbench

- Sequences all external SRAM accesses for the audio FIFO and arbitrates between a sample producer (write port) and a sample consumer (read port).
- Sits between the FIFO pointer/flag controller and the SRAM pins.
  - Takes read/write addresses and empty/full status from the controller.
  - Returns one-cycle pointer-increment pulses to it.
- Generates SRAM CE/OE/WE strobes and the data-bus direction.

---
 rtl/sram_arb_pkg.sv | 32 +++
 rtl/sram_ff_arb_rr.sv | 47 ++++
 rtl/sram_ff_arb.sv | 189 ++++++++++++++++++
 tb/tb_sram_ff_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the audio FIFO SRAM sequencer/arbiter.
// Optional overflow-drop behaviour in the top is selected by SRAM_ARB_OVF_DROP_EN.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned OVF_CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        WR_HOLD   = 3'd3,
        RD_SETUP  = 3'd4,
        RD_WAIT   = 3'd5,
        RD_CAP    = 3'd6
    } state_t;

    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_t;

    function automatic logic is_rd_state(input state_t s);
        return (s == RD_SETUP) || (s == RD_WAIT) || (s == RD_CAP);
    endfunction

    function automatic logic is_wr_state(input state_t s);
        return (s == WR_SETUP) || (s == WR_STROBE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_ff_arb_rr.sv
// Two-requester round-robin grant (write vs read) with a last-served register.
// Grants are combinational and only issued while en_ih is high.
module sram_rr_arb2
    import sram_arb_pkg::*;
(
    input  logic clk_ir,
    input  logic rst_il,
    input  logic en_ih,
    input  logic wr_elig_ih,
    input  logic rd_elig_ih,
    output logic gnt_wr_oh,
    output logic gnt_rd_oh
);

    side_t last_q;
    side_t last_d;

    always_comb begin
        gnt_wr_oh = 1'b0;
        gnt_rd_oh = 1'b0;
        if (en_ih) begin
            if (wr_elig_ih && rd_elig_ih) begin
                // Contention: serve whichever side did not win last time.
                gnt_wr_oh = (last_q == SIDE_RD);
                gnt_rd_oh = (last_q == SIDE_WR);
            end else begin
                gnt_wr_oh = wr_elig_ih;
                gnt_rd_oh = rd_elig_ih;
            end
        end
        last_d = last_q;
        if (gnt_wr_oh) begin
            last_d = SIDE_WR;
        end else if (gnt_rd_oh) begin
            last_d = SIDE_RD;
        end
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            last_q <= SIDE_RD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_ff_arb.sv
// Sequences external SRAM reads/writes for the audio FIFO and arbitrates producer vs consumer.
// Define SRAM_ARB_OVF_DROP_EN to ack-and-discard writes while full and count them on ovf_cnt_od.
module sram_ff_arb
    import sram_arb_pkg::*;
#(
    parameter int unsigned P_SRAM_ADDR_W = SRAM_ADDR_W_DEF,
    parameter int unsigned P_DATA_W      = DATA_W_DEF,
    parameter int unsigned P_RD_WAIT_CYC = 1
) (
    input  logic                     clk_ir,
    input  logic                     rst_il,
    input  logic                     wr_req_ih,
    input  logic [P_DATA_W-1:0]      wr_data_id,
    output logic                     wr_ack_oh,
    input  logic                     rd_req_ih,
    output logic                     rd_ack_oh,
    output logic [P_DATA_W-1:0]      rd_data_od,
    output logic                     rd_valid_oh,
    input  logic                     ff_empty_ih,
    input  logic                     ff_full_ih,
    input  logic [P_SRAM_ADDR_W-1:0] ff_rd_addr_id,
    input  logic [P_SRAM_ADDR_W-1:0] ff_wr_addr_id,
    output logic                     ff_rd_en_oh,
    output logic                     ff_wr_en_oh,
    output logic [P_SRAM_ADDR_W-1:0] sram_addr_od,
    output logic [P_DATA_W-1:0]      sram_dq_od,
    input  logic [P_DATA_W-1:0]      sram_dq_id,
    output logic                     sram_dq_oe_oh,
    output logic                     sram_ce_ln,
    output logic                     sram_oe_ln,
    output logic                     sram_we_ln,
`ifdef SRAM_ARB_OVF_DROP_EN
    output logic [OVF_CNT_W-1:0]     ovf_cnt_od,
`endif
    output logic                     busy_oh,
    output state_t                   dbg_state_od
);

    localparam int unsigned WAIT_W = (P_RD_WAIT_CYC > 1) ? $clog2(P_RD_WAIT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(P_RD_WAIT_CYC - 1);

    state_t                   state_q,    state_d;
    logic [WAIT_W-1:0]        wait_q,     wait_d;
    logic [P_SRAM_ADDR_W-1:0] addr_q,     addr_d;
    logic [P_DATA_W-1:0]      dq_q,       dq_d;
    logic [P_DATA_W-1:0]      rd_data_q,  rd_data_d;
    logic                     ce_q,       ce_d;
    logic                     oe_q,       oe_d;
    logic                     we_q,       we_d;
    logic                     dq_oe_q,    dq_oe_d;
    logic                     wr_en_q,    wr_en_d;
    logic                     rd_en_q,    rd_en_d;
    logic                     rd_valid_q, rd_valid_d;

    logic idle;
    logic wr_elig;
    logic rd_elig;
    logic gnt_wr;
    logic gnt_rd;

    assign idle    = (state_q == IDLE);
    assign wr_elig = wr_req_ih & ~ff_full_ih;
    assign rd_elig = rd_req_ih & ~ff_empty_ih;

    sram_rr_arb2 u_rr (
        .clk_ir     (clk_ir),
        .rst_il     (rst_il),
        .en_ih      (idle),
        .wr_elig_ih (wr_elig),
        .rd_elig_ih (rd_elig),
        .gnt_wr_oh  (gnt_wr),
        .gnt_rd_oh  (gnt_rd)
    );

    // req/ack handshake: ack is combinational, only raised in IDLE, and a
    // request is taken at the clock edge where req and ack are both high.
`ifdef SRAM_ARB_OVF_DROP_EN
    logic                 drop;
    logic [OVF_CNT_W-1:0] ovf_q, ovf_d;

    assign drop      = idle & wr_req_ih & ff_full_ih & ~rd_elig;
    assign wr_ack_oh = gnt_wr | drop;
    assign ovf_d     = (drop && (ovf_q != {OVF_CNT_W{1'b1}})) ? ovf_q + 1'b1 : ovf_q;
    assign ovf_cnt_od = ovf_q;

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    assign wr_ack_oh = gnt_wr;
`endif
    assign rd_ack_oh = gnt_rd;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        dq_d      = dq_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (gnt_wr) begin
                    state_d = WR_SETUP;
                    addr_d  = ff_wr_addr_id;
                    dq_d    = wr_data_id;
                end else if (gnt_rd) begin
                    state_d = RD_SETUP;
                    addr_d  = ff_rd_addr_id;
                end
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: state_d = WR_HOLD;
            WR_HOLD:   state_d = IDLE;
            RD_SETUP: begin
                state_d = RD_WAIT;
                wait_d  = WAIT_INIT;
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    state_d = RD_CAP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RD_CAP: begin
                state_d   = IDLE;
                rd_data_d = sram_dq_id;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so the pins are clean flops.
        ce_d       = (state_d == IDLE);
        oe_d       = ~is_rd_state(state_d);
        we_d       = (state_d != WR_STROBE);
        dq_oe_d    = is_wr_state(state_d);
        wr_en_d    = (state_d == WR_HOLD);
        rd_en_d    = (state_d == RD_CAP);
        rd_valid_d = (state_q == RD_CAP);
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            addr_q     <= '0;
            dq_q       <= '0;
            rd_data_q  <= '0;
            ce_q       <= 1'b1;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            dq_oe_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            dq_q       <= dq_d;
            rd_data_q  <= rd_data_d;
            ce_q       <= ce_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            dq_oe_q    <= dq_oe_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign sram_addr_od  = addr_q;
    assign sram_dq_od    = dq_q;
    assign rd_data_od    = rd_data_q;
    assign sram_ce_ln    = ce_q;
    assign sram_oe_ln    = oe_q;
    assign sram_we_ln    = we_q;
    assign sram_dq_oe_oh = dq_oe_q;
    assign ff_wr_en_oh   = wr_en_q;
    assign ff_rd_en_oh   = rd_en_q;
    assign rd_valid_oh   = rd_valid_q;
    assign busy_oh       = ~idle;
    assign dbg_state_od  = state_q;

endmodule

// File: tb/tb_sram_ff_arb.sv
// Bench for sram_ff_arb with P_RD_WAIT_CYC=2: directed vectors, expected-queue scoreboard,
// SRAM read model returning a fixed pattern per address.
module tb_sram_ff_arb;
    import sram_arb_pkg::*;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk_ir = 1'b0;
    logic          rst_il = 1'b1;
    logic          wr_req_ih, rd_req_ih, ff_empty_ih, ff_full_ih;
    logic [DW-1:0] wr_data_id;
    logic [AW-1:0] ff_rd_addr_id, ff_wr_addr_id;
    logic          wr_ack_oh, rd_ack_oh, rd_valid_oh, ff_rd_en_oh, ff_wr_en_oh;
    logic [DW-1:0] rd_data_od, sram_dq_od, sram_dq_id;
    logic [AW-1:0] sram_addr_od;
    logic          sram_dq_oe_oh, sram_ce_ln, sram_oe_ln, sram_we_ln, busy_oh;
    state_t        dbg_state_od;
`ifdef SRAM_ARB_OVF_DROP_EN
    logic [15:0]   ovf_cnt_od;
`endif

    logic [AW+DW-1:0] wr_exp_q[$];
    logic [DW-1:0]    rd_exp_q[$];
    logic [AW+DW-1:0] we_e;
    logic [DW-1:0]    rd_e;
    int errors = 0;
    int checks = 0;
    int glog_side[16];
    int glog_cyc[16];
    int n_gnt;

    sram_ff_arb #(.P_SRAM_ADDR_W(AW), .P_DATA_W(DW), .P_RD_WAIT_CYC(2)) dut (
        .clk_ir        (clk_ir),
        .rst_il        (rst_il),
        .wr_req_ih     (wr_req_ih),
        .wr_data_id    (wr_data_id),
        .wr_ack_oh     (wr_ack_oh),
        .rd_req_ih     (rd_req_ih),
        .rd_ack_oh     (rd_ack_oh),
        .rd_data_od    (rd_data_od),
        .rd_valid_oh   (rd_valid_oh),
        .ff_empty_ih   (ff_empty_ih),
        .ff_full_ih    (ff_full_ih),
        .ff_rd_addr_id (ff_rd_addr_id),
        .ff_wr_addr_id (ff_wr_addr_id),
        .ff_rd_en_oh   (ff_rd_en_oh),
        .ff_wr_en_oh   (ff_wr_en_oh),
        .sram_addr_od  (sram_addr_od),
        .sram_dq_od    (sram_dq_od),
        .sram_dq_id    (sram_dq_id),
        .sram_dq_oe_oh (sram_dq_oe_oh),
        .sram_ce_ln    (sram_ce_ln),
        .sram_oe_ln    (sram_oe_ln),
        .sram_we_ln    (sram_we_ln),
`ifdef SRAM_ARB_OVF_DROP_EN
        .ovf_cnt_od    (ovf_cnt_od),
`endif
        .busy_oh       (busy_oh),
        .dbg_state_od  (dbg_state_od)
    );

    // clock / SRAM read model
    always #5 clk_ir = ~clk_ir;

    function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
        if (a == 18'h00020) return 16'h1234;
        return {8'hC3, a[7:0]};
    endfunction

    assign sram_dq_id = (!sram_ce_ln && !sram_oe_ln) ? rd_pat(sram_addr_od) : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic do_reset();
        rst_il    = 1'b0;
        wr_req_ih = 1'b0;
        rd_req_ih = 1'b0;
        repeat (2) @(posedge clk_ir);
        #1;
        rst_il = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge clk_ir) begin
        if (rst_il) begin
            if (!sram_we_ln) begin
                if (wr_exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(1), 32'(0));
                end else begin
                    we_e = wr_exp_q.pop_front();
                    chk("wr_addr", 32'(sram_addr_od), 32'(we_e[AW+DW-1:DW]));
                    chk("wr_dq", 32'(sram_dq_od), 32'(we_e[DW-1:0]));
                    chk("wr_ce", 32'(sram_ce_ln), 32'(0));
                    chk("wr_dq_oe", 32'(sram_dq_oe_oh), 32'(1));
                end
            end
            if (rd_valid_oh) begin
                if (rd_exp_q.size() == 0) begin
                    chk("rd_unexpected", 32'(1), 32'(0));
                end else begin
                    rd_e = rd_exp_q.pop_front();
                    chk("rd_data", 32'(rd_data_od), 32'(rd_e));
                end
            end
            chk("bus_turn", 32'(!sram_oe_ln && sram_dq_oe_oh), 32'(0));
            chk("dual_ack", 32'(wr_ack_oh && rd_ack_oh), 32'(0));
        end
    end

    initial begin
        logic pw, pr;
        wr_req_ih = 0; rd_req_ih = 0; wr_data_id = '0;
        ff_empty_ih = 1; ff_full_ih = 0; ff_rd_addr_id = '0; ff_wr_addr_id = '0;
        #2 rst_il = 1'b0;
        #10;
        chk("rst_ce", 32'(sram_ce_ln), 32'(1));
        chk("rst_oe", 32'(sram_oe_ln), 32'(1));
        chk("rst_we", 32'(sram_we_ln), 32'(1));
        chk("rst_dq_oe", 32'(sram_dq_oe_oh), 32'(0));
        chk("rst_pulses", 32'({ff_rd_en_oh, ff_wr_en_oh, rd_valid_oh}), 32'(0));
        chk("rst_addr", 32'(sram_addr_od), 32'(0));
        chk("rst_dq", 32'(sram_dq_od), 32'(0));
        chk("rst_rd_data", 32'(rd_data_od), 32'(0));
        chk("rst_busy", 32'(busy_oh), 32'(0));
        @(posedge clk_ir);
        #1 rst_il = 1'b1;

        // single write
        wr_req_ih = 1; wr_data_id = 16'hA5A5; ff_wr_addr_id = 18'h00010;
        wr_exp_q.push_back({18'h00010, 16'hA5A5});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_ir);
            chk($sformatf("w_ack_c%0d", c), 32'(wr_ack_oh), 32'(c == 0));
            chk($sformatf("w_we_c%0d", c), 32'(!sram_we_ln), 32'(c == 2));
            chk($sformatf("w_en_c%0d", c), 32'(ff_wr_en_oh), 32'(c == 3));
            chk($sformatf("w_busy_c%0d", c), 32'(busy_oh), 32'(c >= 1 && c <= 3));
            tick();
            if (c == 0) wr_req_ih = 0;
        end

        // single read, wait = 2
        ff_empty_ih = 0; ff_rd_addr_id = 18'h00020; rd_req_ih = 1;
        rd_exp_q.push_back(16'h1234);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_ir);
            chk($sformatf("r_ack_c%0d", c), 32'(rd_ack_oh), 32'(c == 0));
            chk($sformatf("r_oe_c%0d", c), 32'(!sram_oe_ln), 32'(c >= 1 && c <= 4));
            chk($sformatf("r_en_c%0d", c), 32'(ff_rd_en_oh), 32'(c == 4));
            chk($sformatf("r_valid_c%0d", c), 32'(rd_valid_oh), 32'(c == 5));
            chk($sformatf("r_dq_oe_c%0d", c), 32'(sram_dq_oe_oh), 32'(0));
            tick();
            if (c == 0) rd_req_ih = 0;
        end

        // alternating traffic from reset
        do_reset();
        ff_empty_ih = 0; ff_full_ih = 0;
        ff_wr_addr_id = 18'h00040; wr_data_id = 16'h1000; ff_rd_addr_id = 18'h00080;
        wr_req_ih = 1; rd_req_ih = 1; n_gnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_ir);
            if (wr_ack_oh && n_gnt < 16) begin
                wr_exp_q.push_back({ff_wr_addr_id, wr_data_id});
                glog_side[n_gnt] = 0; glog_cyc[n_gnt] = c; n_gnt++;
            end
            if (rd_ack_oh && n_gnt < 16) begin
                rd_exp_q.push_back(rd_pat(ff_rd_addr_id));
                glog_side[n_gnt] = 1; glog_cyc[n_gnt] = c; n_gnt++;
            end
            pw = ff_wr_en_oh; pr = ff_rd_en_oh;
            tick();
            if (pw) begin ff_wr_addr_id = ff_wr_addr_id + 1'b1; wr_data_id = wr_data_id + 16'h1111; end
            if (pr) ff_rd_addr_id = ff_rd_addr_id + 1'b1;
        end
        wr_req_ih = 0; rd_req_ih = 0;
        chk("alt_count", 32'(n_gnt >= 6), 32'(1));
        chk("alt_first_cyc", 32'(glog_cyc[0]), 32'(0));
        for (int i = 0; i < 6; i++) begin
            if (i < n_gnt) chk($sformatf("alt_side_%0d", i), 32'(glog_side[i]), 32'(i % 2));
            if (i > 0 && i < n_gnt)
                chk($sformatf("alt_gap_%0d", i), 32'(glog_cyc[i] - glog_cyc[i-1]), 32'((i % 2 == 1) ? 4 : 5));
        end
        repeat (8) tick();

        // empty blocks reads
        ff_empty_ih = 1; rd_req_ih = 1; ff_rd_addr_id = 18'h00090;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_ir);
            chk($sformatf("empty_ack_c%0d", c), 32'(rd_ack_oh), 32'(0));
            chk($sformatf("empty_oe_c%0d", c), 32'(sram_oe_ln), 32'(1));
            tick();
        end
        ff_empty_ih = 0;
        rd_exp_q.push_back(rd_pat(18'h00090));
        @(negedge clk_ir);
        chk("unempty_ack", 32'(rd_ack_oh), 32'(1));
        tick();
        rd_req_ih = 0;
        repeat (8) tick();

        // full blocks or drops writes
        ff_full_ih = 1; wr_req_ih = 1; wr_data_id = 16'hBEEF; ff_wr_addr_id = 18'h000A0;
`ifdef SRAM_ARB_OVF_DROP_EN
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_ir);
            chk($sformatf("drop_ack_c%0d", c), 32'(wr_ack_oh), 32'(1));
            chk($sformatf("drop_we_c%0d", c), 32'(sram_we_ln), 32'(1));
            chk($sformatf("drop_en_c%0d", c), 32'(ff_wr_en_oh), 32'(0));
            tick();
        end
        wr_req_ih = 0;
        @(negedge clk_ir);
        chk("ovf_cnt", 32'(ovf_cnt_od), 32'(5));
        tick();
`else
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_ir);
            chk($sformatf("full_ack_c%0d", c), 32'(wr_ack_oh), 32'(0));
            chk($sformatf("full_we_c%0d", c), 32'(sram_we_ln), 32'(1));
            chk($sformatf("full_busy_c%0d", c), 32'(busy_oh), 32'(0));
            tick();
        end
        wr_req_ih = 0;
`endif
        ff_full_ih = 0;
        repeat (2) tick();

        // reset during WR_STROBE
        wr_req_ih = 1; wr_data_id = 16'h5A5A; ff_wr_addr_id = 18'h00055;
        wr_exp_q.push_back({18'h00055, 16'h5A5A});
        @(negedge clk_ir);
        chk("abort_ack", 32'(wr_ack_oh), 32'(1));
        tick();
        wr_req_ih = 0;
        tick();
        @(negedge clk_ir);
        chk("abort_state", 32'(dbg_state_od), 32'(WR_STROBE));
        #1 rst_il = 1'b0;
        #1;
        chk("abort_we", 32'(sram_we_ln), 32'(1));
        chk("abort_ce", 32'(sram_ce_ln), 32'(1));
        chk("abort_dq_oe", 32'(sram_dq_oe_oh), 32'(0));
        chk("abort_busy", 32'(busy_oh), 32'(0));
        repeat (2) begin
            @(negedge clk_ir);
            chk("abort_wr_en", 32'(ff_wr_en_oh), 32'(0));
        end
        @(posedge clk_ir);
        #1 rst_il = 1'b1;
        ff_empty_ih = 0; wr_req_ih = 1; rd_req_ih = 1;
        wr_data_id = 16'h0F0F; ff_wr_addr_id = 18'h00060;
        wr_exp_q.push_back({18'h00060, 16'h0F0F});
        @(negedge clk_ir);
        chk("post_rst_state", 32'(dbg_state_od), 32'(IDLE));
        chk("post_rst_wr_ack", 32'(wr_ack_oh), 32'(1));
        chk("post_rst_rd_ack", 32'(rd_ack_oh), 32'(0));
        tick();
        wr_req_ih = 0; rd_req_ih = 0;
        repeat (8) tick();

        chk("wr_q_drained", 32'(wr_exp_q.size()), 32'(0));
        chk("rd_q_drained", 32'(rd_exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
